// File: rtl/resgen_luma16x16_if.sv
// Pixel-in / residual-out handshake bundle for the 16x16 luma residual generator.
// The master modport is the generator side; the slave modport is the environment side.
interface resgen_luma16x16_if #(parameter int BITDEPTH = 8);
    logic                pix_valid;
    logic                pix_ready;
    logic [BITDEPTH-1:0] pix_data;
    logic                res_valid;
    logic                res_ready;
    logic [BITDEPTH:0]   vres;
    logic [BITDEPTH:0]   hres;
    logic [BITDEPTH:0]   dcres;
    logic [7:0]          res_idx;
    logic                res_last;

    modport master (
        input  pix_valid, pix_data, res_ready,
        output pix_ready, res_valid, vres, hres, dcres, res_idx, res_last
    );

    modport slave (
        output pix_valid, pix_data, res_ready,
        input  pix_ready, res_valid, vres, hres, dcres, res_idx, res_last
    );
endinterface

// File: rtl/resgen_luma16x16.sv
// 16x16 luma intra residual generator: latches neighbours, builds DC over 16 cycles,
// then streams vertical/horizontal/DC residuals. Define RESGEN_ABS_EN for absolute residuals.
module resgen_luma16x16 #(
    parameter int BITDEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         start,
    input  logic [15:0][BITDEPTH-1:0]    top,
    input  logic [15:0][BITDEPTH-1:0]    left,
    input  logic                         top_avail,
    input  logic                         left_avail,
    resgen_luma16x16_if.master           bus,
    output logic                         busy,
    output logic                         done
);

    localparam int SW = BITDEPTH + 4;
    localparam int BW = BITDEPTH + 5;
    localparam logic [BITDEPTH-1:0] MID = {1'b1, {(BITDEPTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DCSUM, STREAM, DONE} state_e;

    state_e                      state_q;
    logic [15:0][BITDEPTH-1:0]   top_q, left_q;
    logic [15:0][BITDEPTH-1:0]   top_cap, left_cap;
    logic                        top_av_q, left_av_q;
    logic [SW-1:0]               sum_t_q, sum_l_q, sum_t_d, sum_l_d;
    logic [BW-1:0]               sum_both;
    logic [3:0]                  k_q;
    logic [BITDEPTH-1:0]         dc_q, dc_d;
    logic [8:0]                  cnt_q;
    logic                        res_valid_q, res_last_q;
    logic [BITDEPTH:0]           vres_q, hres_q, dcres_q;
    logic [BITDEPTH:0]           vres_d, hres_d, dcres_d;
    logic [7:0]                  res_idx_q;
    logic                        pix_ready_w, pix_hs, res_hs;

    // Residual in BITDEPTH+1 bits; optionally folded to magnitude for the SAD stage.
    function automatic logic [BITDEPTH:0] resid(input logic [BITDEPTH-1:0] a,
                                                 input logic [BITDEPTH-1:0] b);
        logic [BITDEPTH:0] d;
        d = {1'b0, a} - {1'b0, b};
`ifdef RESGEN_ABS_EN
        if (d[BITDEPTH]) begin
            d = -d;
        end
`endif
        return d;
    endfunction

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            top_cap[i]  = top_avail  ? top[i]  : MID;
            left_cap[i] = left_avail ? left[i] : MID;
        end
    end

    // DC accumulation with the final rounding applied on the last DCSUM cycle.
    always_comb begin
        sum_t_d  = sum_t_q + SW'(top_q[k_q]);
        sum_l_d  = sum_l_q + SW'(left_q[k_q]);
        sum_both = BW'(sum_t_d) + BW'(sum_l_d) + BW'(16);
        case ({top_av_q, left_av_q})
            2'b11:   dc_d = BITDEPTH'(sum_both >> 5);
            2'b10:   dc_d = BITDEPTH'((sum_t_d + SW'(8)) >> 4);
            2'b01:   dc_d = BITDEPTH'((sum_l_d + SW'(8)) >> 4);
            default: dc_d = MID;
        endcase
    end

    assign pix_ready_w = (state_q == STREAM) && enable && (!res_valid_q || bus.res_ready)
                         && !cnt_q[8];
    assign pix_hs      = bus.pix_valid && pix_ready_w;
    assign res_hs      = res_valid_q && bus.res_ready;

    always_comb begin
        vres_d  = resid(bus.pix_data, top_q[cnt_q[3:0]]);
        hres_d  = resid(bus.pix_data, left_q[cnt_q[7:4]]);
        dcres_d = resid(bus.pix_data, dc_q);
    end

    // Control FSM and the single output register stage; enable low freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            top_q       <= '0;
            left_q      <= '0;
            top_av_q    <= 1'b0;
            left_av_q   <= 1'b0;
            sum_t_q     <= '0;
            sum_l_q     <= '0;
            k_q         <= '0;
            dc_q        <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_idx_q   <= '0;
            vres_q      <= '0;
            hres_q      <= '0;
            dcres_q     <= '0;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        top_q     <= top_cap;
                        left_q    <= left_cap;
                        top_av_q  <= top_avail;
                        left_av_q <= left_avail;
                        sum_t_q   <= '0;
                        sum_l_q   <= '0;
                        k_q       <= '0;
                        cnt_q     <= '0;
                        state_q   <= DCSUM;
                    end
                end
                DCSUM: begin
                    sum_t_q <= sum_t_d;
                    sum_l_q <= sum_l_d;
                    k_q     <= k_q + 4'd1;
                    if (k_q == 4'd15) begin
                        dc_q    <= dc_d;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (pix_hs) begin
                        res_valid_q <= 1'b1;
                        vres_q      <= vres_d;
                        hres_q      <= hres_d;
                        dcres_q     <= dcres_d;
                        res_idx_q   <= cnt_q[7:0];
                        res_last_q  <= (cnt_q == 9'd255);
                        cnt_q       <= cnt_q + 9'd1;
                    end else if (res_hs) begin
                        res_valid_q <= 1'b0;
                    end
                    if (res_hs && res_last_q) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    res_last_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pix_ready = pix_ready_w;
    assign bus.res_valid = res_valid_q;
    assign bus.vres      = vres_q;
    assign bus.hres      = hres_q;
    assign bus.dcres     = dcres_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.res_last  = res_last_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: doc/resgen_luma16x16.md
# resgen_luma16x16

Residual generator for 16x16 luma intra prediction. It latches the top and left neighbour rows and derives the DC predictor over 16 cycles. It then streams the 256 block samples in raster order and emits vertical, horizontal and DC residuals per sample over a valid/ready handshake. It sits directly upstream of the 16x16 SAD stage and supplies the residual arrays that stage sums into per-mode SADs.

## Interface
- BITDEPTH, 8, sample width in bits
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  global stall; low freezes all state, pix_ready=0, outputs held
- start  input  1  begin a block; sampled only in IDLE
- top  input  BITDEPTH x [15:0]  top neighbour row, captured on accepted start
- left  input  BITDEPTH x [15:0]  left neighbour column, captured on accepted start
- top_avail  input  1  top row usable, captured on accepted start
- left_avail  input  1  left column usable, captured on accepted start
- pix_valid  input  1  pix_data valid
- pix_ready  output  1  block accepts a sample
- pix_data  input  BITDEPTH  original sample, raster order (row-major)
- res_valid  output  1  residual triple valid
- res_ready  input  1  consumer accepts residuals
- vres, hres, dcres  output  BITDEPTH+1 each  signed residuals (sample − predictor)
- res_idx  output  8  raster index of current residual, 0..255
- res_last  output  1  high with res_idx=255
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after index 255 is accepted downstream

## Operation
- FSM states: IDLE, DCSUM, STREAM, DONE.
- IDLE: on start=1, capture top, left, top_avail and left_avail, clear the sums, and go to DCSUM. start in other states is ignored.
- DCSUM: 16 cycles. Cycle k adds top[k] to sumT and left[k] to sumL. sumT and sumL are BITDEPTH+4 bits each. At the end, the DC predictor is registered and the FSM moves to STREAM.
- DC predictor:
  - both available: (sumT+sumL+16)>>5
  - top only: (sumT+8)>>4
  - left only: (sumL+8)>>4
  - neither: 1<<(BITDEPTH−1), i.e. 128.
- Unavailable neighbours are substituted with 1<<(BITDEPTH−1) for the vertical and horizontal predictors.
- STREAM: a sample count c (0..255) advances on each pix handshake. row=c[7:4], col=c[3:0].
  - vres = pix − top[col]
  - hres = pix − left[row]
  - dcres = pix − dc
  - Subtraction is zero-extended to BITDEPTH+1, then two's complement. The range −255..255 fits without saturation.
- After the residual at index 255 is accepted downstream, the FSM enters DONE. It pulses done for one cycle and returns to IDLE.
- Output stage is a single register: pix_ready = STREAM & enable & (!res_valid | res_ready). No skid buffer.
- Samples beyond 256 are not accepted; pix_ready is 0 once c has wrapped past 255.

## Timing
- Reset values: state=IDLE, res_valid=0, pix_ready=0, busy=0, done=0, res_last=0, res_idx=0, vres=hres=dcres=0, sums=0, dc=0.
- Reset is asynchronous and may be asserted mid-operation. The block returns to IDLE immediately, partial output is discarded, and no done pulse is produced.
- Latency:
  - start accepted at edge E0: busy=1 after E0.
  - First pix_ready=1 after edge E16 (16 DCSUM cycles).
  - A sample accepted at edge N has its residual on the outputs, with res_valid=1, after edge N.
- Throughput: one residual per cycle with continuous valid/ready.
- Handshakes:
  - res_valid is held, with stable data, until res_ready.
  - An accept on pix and an output on res can coincide in one cycle (pipe refill).
- done asserts the cycle after the res handshake with res_last=1. busy falls with done.
- enable=0 holds every register, including DCSUM progress. res_valid stays asserted, but no transfer completes while enable=0.

## Configuration
- RESGEN_ABS_EN defined: vres, hres and dcres carry the absolute value of the residual, zero-extended to BITDEPTH+1 bits with MSB=0. The downstream SAD stage then sums them without sign handling.
- RESGEN_ABS_EN undefined: signed two's-complement residuals as specified above.

## Test plan
- Both available, top all 100, left all 60, flat block of 80 → dc=80. Index 0 gives vres=−20, hres=20, dcres=0. res_last and done appear once, on index 255.
- top_avail=0, left_avail=1, left all 200, block all 200 → dc=200. vres=72, since top is substituted by 128. hres=0 and dcres=0 for every sample.
- Neither available, block ramp pix=c mod 256 → dc=128. Index 5: dcres=−123. Index 255: dcres=127. With RESGEN_ABS_EN: index 5 dcres=123.
- Random res_ready and pix_valid backpressure over a full block → exactly 256 transfers, res_idx strictly 0..255, and data stable whenever res_valid & !res_ready.
- Reset pulsed at sample 100 → outputs reach reset values immediately with no done. A new start afterwards completes a full 256-sample block.
- enable low for 5 cycles mid-DCSUM and mid-STREAM → first pix_ready is delayed by exactly 5 cycles, and residual values are unchanged.
